// File: rtl/procc_unit.sv
// procc_unit: processing stage fed by the memory controller and started by the
// core controller. A start pulse latches the opcode and the operand-pair count.
// The unit then consumes that many opa/opb pairs and produces one registered
// result per pair, plus a running accumulator. It pulses procc_done when the
// last result is out.
//
// Ports:
//   procc_clk, procc_reset           clock, synchronous active-high reset
//   procc_start                      one-cycle job start (honoured in IDLE only)
//   procc_instruction                opcode, sampled with procc_start
//   procc_data_length                operand-pair count, sampled with procc_start
//   procc_opa, procc_opb             operand pair
//   procc_data_valid                 operand pair valid this cycle
//   procc_ready                      a pair is accepted this cycle if valid
//   procc_result, procc_result_valid per-pair result, valid one cycle
//   procc_acc                        running MAC sum, or the latest result
//   procc_overflow                   sticky per-job overflow
//   procc_busy, procc_done           job in progress, job-complete pulse
module procc_unit #(
    parameter int DATA_WIDTH = 32,
    parameter int LEN_WIDTH  = 6
) (
    input  logic                  procc_clk,
    input  logic                  procc_reset,
    input  logic                  procc_start,
    input  logic [2:0]            procc_instruction,
    input  logic [LEN_WIDTH-1:0]  procc_data_length,
    input  logic [DATA_WIDTH-1:0] procc_opa,
    input  logic [DATA_WIDTH-1:0] procc_opb,
    input  logic                  procc_data_valid,
    output logic                  procc_ready,
    output logic [DATA_WIDTH-1:0] procc_result,
    output logic                  procc_result_valid,
    output logic [DATA_WIDTH-1:0] procc_acc,
    output logic                  procc_overflow,
    output logic                  procc_busy,
    output logic                  procc_done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100,
        OP_MUL = 3'b101,
        OP_MAC = 3'b110,
        OP_MAX = 3'b111
    } op_t;

    state_t                  r_state;
    state_t                  w_state_next;
    op_t                     r_opcode;
    logic [LEN_WIDTH-1:0]    r_len;
    logic [LEN_WIDTH-1:0]    r_cnt;
    logic [DATA_WIDTH-1:0]   r_result;
    logic                    r_result_valid;
    logic [DATA_WIDTH-1:0]   r_acc;
    logic                    r_overflow;

    logic                    w_accept;
    logic [LEN_WIDTH-1:0]    w_cnt_next;
    logic                    w_last;
    logic [DATA_WIDTH:0]     w_add;
    logic [2*DATA_WIDTH-1:0] w_prod;
    logic                    w_prod_hi_nz;
    logic [DATA_WIDTH:0]     w_mac_sum;
    logic [DATA_WIDTH-1:0]   w_res;
    logic                    w_ovf;
    logic [DATA_WIDTH-1:0]   w_acc_next;

    // Acceptance is derived from the registered state, not from procc_ready,
    // so that the FSM output does not loop back into its own input.
    assign w_accept   = (r_state == S_RUN) && procc_data_valid;
    assign w_cnt_next = r_cnt + LEN_WIDTH'(1);
    assign w_last     = (w_cnt_next == r_len);

    always_ff @(posedge procc_clk) begin
        if (procc_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        procc_ready  = 1'b0;
        procc_busy   = 1'b0;
        procc_done   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (procc_start) begin
                    w_state_next = (procc_data_length == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                procc_ready = 1'b1;
                procc_busy  = 1'b1;
                if (w_accept && w_last) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                procc_busy   = 1'b1;
                procc_done   = 1'b1;
                w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    assign w_add        = {1'b0, procc_opa} + {1'b0, procc_opb};
    assign w_prod       = (2*DATA_WIDTH)'(procc_opa) * (2*DATA_WIDTH)'(procc_opb);
    assign w_prod_hi_nz = |w_prod[2*DATA_WIDTH-1:DATA_WIDTH];
    assign w_mac_sum    = {1'b0, r_acc} + {1'b0, w_prod[DATA_WIDTH-1:0]};

    always_comb begin
        w_res      = '0;
        w_ovf      = 1'b0;
        w_acc_next = '0;
        case (r_opcode)
            OP_ADD: begin
                w_res = w_add[DATA_WIDTH-1:0];
                w_ovf = w_add[DATA_WIDTH];
            end
            OP_SUB: begin
                w_res = procc_opa - procc_opb;
                w_ovf = (procc_opa < procc_opb);
            end
            OP_AND: w_res = procc_opa & procc_opb;
            OP_OR:  w_res = procc_opa | procc_opb;
            OP_XOR: w_res = procc_opa ^ procc_opb;
            OP_MUL: begin
                w_res = w_prod[DATA_WIDTH-1:0];
                w_ovf = w_prod_hi_nz;
            end
            OP_MAC: begin
                w_res = w_prod[DATA_WIDTH-1:0];
                w_ovf = w_prod_hi_nz | w_mac_sum[DATA_WIDTH];
            end
            OP_MAX: w_res = (procc_opa > procc_opb) ? procc_opa : procc_opb;
            default: w_res = '0;
        endcase
        // MAC keeps a running sum; every other opcode mirrors the latest result.
        w_acc_next = (r_opcode == OP_MAC) ? w_mac_sum[DATA_WIDTH-1:0] : w_res;
    end

    always_ff @(posedge procc_clk) begin
        if (procc_reset) begin
            r_opcode       <= OP_ADD;
            r_len          <= '0;
            r_cnt          <= '0;
            r_result       <= '0;
            r_result_valid <= 1'b0;
            r_acc          <= '0;
            r_overflow     <= 1'b0;
        end else begin
            r_result_valid <= 1'b0;
            if ((r_state == S_IDLE) && procc_start) begin
                r_opcode   <= op_t'(procc_instruction);
                r_len      <= procc_data_length;
                r_cnt      <= '0;
                r_acc      <= '0;
                r_overflow <= 1'b0;
            end else if (w_accept) begin
                r_cnt          <= w_cnt_next;
                r_result       <= w_res;
                r_result_valid <= 1'b1;
                r_acc          <= w_acc_next;
                r_overflow     <= r_overflow | w_ovf;
            end
        end
    end

    assign procc_result       = r_result;
    assign procc_result_valid = r_result_valid;
    assign procc_acc          = r_acc;
    assign procc_overflow     = r_overflow;

endmodule

// File: tb/tb_procc_unit.sv
// tb_procc_unit: self-checking bench for procc_unit.
// Inputs change just after each falling edge, and outputs are sampled at the
// falling edge. Expected per-pair results are queued when a pair is driven
// into a ready unit. They are popped and compared whenever result_valid is seen.
module tb_procc_unit;

    localparam int DW = 32;
    localparam int LW = 6;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [2:0]    instr;
    logic [LW-1:0] length;
    logic [DW-1:0] opa;
    logic [DW-1:0] opb;
    logic          valid;
    logic          ready;
    logic [DW-1:0] result;
    logic          rv;
    logic [DW-1:0] acc;
    logic          ovf;
    logic          busy;
    logic          done;

    always #5 clk = ~clk;

    procc_unit #(.DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
        .procc_clk          (clk),
        .procc_reset        (reset),
        .procc_start        (start),
        .procc_instruction  (instr),
        .procc_data_length  (length),
        .procc_opa          (opa),
        .procc_opb          (opb),
        .procc_data_valid   (valid),
        .procc_ready        (ready),
        .procc_result       (result),
        .procc_result_valid (rv),
        .procc_acc          (acc),
        .procc_overflow     (ovf),
        .procc_busy         (busy),
        .procc_done         (done)
    );

    typedef struct {
        logic [31:0] res;
        logic [31:0] acc;
        logic        ovf;
    } exp_t;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        ovf;
    } vec_t;

    exp_t        sb[$];
    vec_t        vt[11];
    int          checks = 0;
    int          errors = 0;
    int          done_cnt = 0;
    int          rv_cnt = 0;
    bit          ready_seen = 1'b0;
    logic [2:0]  m_op;
    logic [31:0] m_acc;
    logic        m_ovf;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic observe();
        exp_t e;
        if (rv === 1'b1) begin
            rv_cnt++;
            if (sb.size() == 0) begin
                check("unexpected_result_valid", 64'd1, 64'd0);
            end else begin
                e = sb.pop_front();
                check("result", 64'(result), 64'(e.res));
                check("acc", 64'(acc), 64'(e.acc));
                check("overflow", 64'(ovf), 64'(e.ovf));
            end
        end
        if (done === 1'b1) done_cnt++;
        if (ready === 1'b1) ready_seen = 1'b1;
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        observe();
    endtask

    task automatic model_exp(input logic [31:0] a, input logic [31:0] b, output exp_t e);
        logic [63:0] p;
        logic [32:0] s;
        logic [31:0] r;
        logic        o;
        p = {32'b0, a} * {32'b0, b};
        o = 1'b0;
        case (m_op)
            3'd0: begin s = {1'b0, a} + {1'b0, b}; r = s[31:0]; o = s[32]; end
            3'd1: begin r = a - b; o = (a < b); end
            3'd2: r = a & b;
            3'd3: r = a | b;
            3'd4: r = a ^ b;
            3'd5: begin r = p[31:0]; o = |p[63:32]; end
            3'd6: begin
                r = p[31:0];
                s = {1'b0, m_acc} + {1'b0, r};
                o = (|p[63:32]) | s[32];
            end
            default: r = (a > b) ? a : b;
        endcase
        m_acc = (m_op == 3'd6) ? s[31:0] : r;
        m_ovf = m_ovf | o;
        e.res = r;
        e.acc = m_acc;
        e.ovf = m_ovf;
    endtask

    task automatic start_job(input logic [2:0] op, input logic [LW-1:0] len);
        instr  = op;
        length = len;
        start  = 1'b1;
        m_op   = op;
        m_acc  = '0;
        m_ovf  = 1'b0;
        tick();
        start  = 1'b0;
    endtask

    task automatic send_exp(input logic [31:0] a, input logic [31:0] b, input exp_t e);
        int w;
        w = 0;
        while (ready !== 1'b1 && w < 10) begin
            tick();
            w++;
        end
        if (ready !== 1'b1) begin
            check("ready_timeout", 64'd0, 64'd1);
        end else begin
            opa   = a;
            opb   = b;
            valid = 1'b1;
            sb.push_back(e);
            tick();
            valid = 1'b0;
        end
    endtask

    task automatic send(input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        model_exp(a, b, e);
        send_exp(a, b, e);
    endtask

    initial begin
        int   d0;
        int   r0;
        exp_t e;

        vt[0]  = '{3'd0, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 1'b1};
        vt[1]  = '{3'd1, 32'd3,         32'd5,         32'hFFFF_FFFE, 1'b1};
        vt[2]  = '{3'd1, 32'd5,         32'd3,         32'd2,         1'b0};
        vt[3]  = '{3'd2, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1'b0};
        vt[4]  = '{3'd3, 32'h0F0F_0000, 32'h0000_00F0, 32'h0F0F_00F0, 1'b0};
        vt[5]  = '{3'd4, 32'hFFFF_0000, 32'h0F0F_0F0F, 32'hF0F0_0F0F, 1'b0};
        vt[6]  = '{3'd5, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 1'b1};
        vt[7]  = '{3'd5, 32'h0000_FFFF, 32'h0000_FFFF, 32'hFFFE_0001, 1'b0};
        vt[8]  = '{3'd6, 32'h0001_2345, 32'h0000_0010, 32'h0012_3450, 1'b0};
        vt[9]  = '{3'd7, 32'hFFFF_FFFF, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0};
        vt[10] = '{3'd7, 32'd3,         32'h8000_0000, 32'h8000_0000, 1'b0};

        reset = 1'b1; start = 1'b0; instr = '0; length = '0;
        opa = '0; opb = '0; valid = 1'b0;
        m_op = '0; m_acc = '0; m_ovf = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        check("rst_result", 64'(result), 64'd0);
        check("rst_rv", 64'(rv), 64'd0);
        check("rst_acc", 64'(acc), 64'd0);
        check("rst_ovf", 64'(ovf), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_ready", 64'(ready), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        tick();

        // ADD, length 3: results 3, 0, 10 back to back, carry sets overflow
        d0 = done_cnt; r0 = rv_cnt;
        start_job(3'd0, 6'd3);
        send(32'd1, 32'd2);
        send(32'hFFFF_FFFF, 32'd1);
        send(32'd5, 32'd5);
        check("add_done_with_last_rv", 64'({done, rv}), 64'b11);
        tick();
        check("add_busy_after", 64'(busy), 64'd0);
        check("add_overflow", 64'(ovf), 64'd1);
        check("add_done_count", 64'(done_cnt - d0), 64'd1);
        check("add_rv_count", 64'(rv_cnt - r0), 64'd3);

        // MAC, length 4, with a two-cycle gap between pairs 2 and 3
        start_job(3'd6, 6'd4);
        send(32'd2, 32'd3);
        send(32'd4, 32'd5);
        r0 = rv_cnt;
        tick();
        tick();
        check("mac_gap_no_rv", 64'(rv_cnt - r0), 64'd0);
        send(32'd1, 32'd1);
        send(32'd10, 32'd10);
        check("mac_done", 64'(done), 64'd1);
        check("mac_acc_final", 64'(acc), 64'd127);
        check("mac_overflow", 64'(ovf), 64'd0);
        tick();

        // Length 0 SUB: done right after start, no results, never ready
        ready_seen = 1'b0; d0 = done_cnt; r0 = rv_cnt;
        start_job(3'd1, 6'd0);
        check("len0_done_next_cycle", 64'(done), 64'd1);
        tick();
        tick();
        check("len0_busy", 64'(busy), 64'd0);
        check("len0_acc", 64'(acc), 64'd0);
        check("len0_ready_seen", 64'(ready_seen), 64'd0);
        check("len0_rv_count", 64'(rv_cnt - r0), 64'd0);
        check("len0_done_count", 64'(done_cnt - d0), 64'd1);

        // XOR, length 2, with a start pulse during RUN that must be ignored
        d0 = done_cnt; r0 = rv_cnt;
        start_job(3'd4, 6'd2);
        instr = 3'd0; length = 6'd7; start = 1'b1;
        send(32'h0000_F0F0, 32'h0000_0FF0);
        start = 1'b0;
        send(32'h0000_AAAA, 32'h0000_AAAA);
        for (int i = 0; i < 4; i++) tick();
        check("xor_done_count", 64'(done_cnt - d0), 64'd1);
        check("xor_rv_count", 64'(rv_cnt - r0), 64'd2);
        check("xor_busy", 64'(busy), 64'd0);

        // MUL, length 5, reset after the first accepted pair
        d0 = done_cnt;
        start_job(3'd5, 6'd5);
        send(32'd3, 32'd4);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("abort_result", 64'(result), 64'd0);
        check("abort_rv", 64'(rv), 64'd0);
        check("abort_acc", 64'(acc), 64'd0);
        check("abort_ovf", 64'(ovf), 64'd0);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_ready", 64'(ready), 64'd0);
        for (int i = 0; i < 3; i++) tick();
        check("abort_no_done", 64'(done_cnt - d0), 64'd0);
        start_job(3'd7, 6'd1);
        send(32'd7, 32'd9);
        check("max_after_abort_done", 64'(done), 64'd1);
        tick();

        // Single-pair job per table row, checked against fixed expectations
        for (int i = 0; i < 11; i++) begin
            start_job(vt[i].op, 6'd1);
            e.res = vt[i].res;
            e.acc = vt[i].res;
            e.ovf = vt[i].ovf;
            send_exp(vt[i].a, vt[i].b, e);
            check("vec_done", 64'(done), 64'd1);
            tick();
        end

        check("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
